// File: rtl/tanh_backward_if.sv
// Streaming valid/ready bundle for tanh_backward_module.
// Input pair (y, grad) in, input gradient out.
interface tanh_backward_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] y_data;
    logic [DATA_W-1:0] grad_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output y_data,
        output grad_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  y_data,
        input  grad_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/tanh_backward_module.sv
// Tanh backward: out = grad * (1 - y*y), 3-stage elastic pipeline.
// Define TANH_BWD_ROUND_EN for round-half-up shifts (default: truncate).
module tanh_backward_module #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    tanh_backward_if.slave  bus
);
    localparam int SQ_W = 2 * DATA_W;
    localparam int P_W  = 2 * DATA_W + 1;
    localparam int OM_W = DATA_W + 1;

    localparam logic [SQ_W-1:0] ONE_SQ = SQ_W'(1) << FRAC_W;
`ifdef TANH_BWD_ROUND_EN
    localparam logic [SQ_W-1:0]        RND_SQ = SQ_W'(1) << (FRAC_W - 1);
    localparam logic signed [P_W-1:0]  RND_P  = P_W'(1) << (FRAC_W - 1);
`else
    localparam logic [SQ_W-1:0]        RND_SQ = '0;
    localparam logic signed [P_W-1:0]  RND_P  = '0;
`endif

    logic              v1, v2, v3;
    logic [SQ_W-1:0]   sq1;
    logic [DATA_W-1:0] g1, g2;
    logic [OM_W-1:0]   om2;
    logic [DATA_W-1:0] d3;

    logic              ready1, ready2, ready3;
    logic signed [SQ_W-1:0] y_sq;
    logic [SQ_W-1:0]   sq_rnd, sq_sh;
    logic [OM_W-1:0]   om_nxt;
    logic signed [P_W-1:0]  p, ps;
    logic [DATA_W-1:0] out_nxt;

    // A stage may load when empty or when its content moves on.
    assign ready3      = !v3 || bus.out_ready;
    assign ready2      = !v2 || ready3;
    assign ready1      = !v1 || ready2;
    assign bus.in_ready  = !rst && ready1;
    assign bus.out_valid = v3;
    assign bus.out_data  = d3;

    // Datapath: square, clamped complement, scale.
    always_comb begin
        y_sq    = $signed(bus.y_data) * $signed(bus.y_data);
        sq_rnd  = sq1 + RND_SQ;
        sq_sh   = sq_rnd >> FRAC_W;
        om_nxt  = '0;
        if (sq_sh < ONE_SQ) begin
            om_nxt = OM_W'(ONE_SQ - sq_sh);
        end
        p       = $signed(g2) * $signed({1'b0, om2});
        ps      = (p + RND_P) >>> FRAC_W;
        out_nxt = DATA_W'(ps);
    end

    // Stage registers; stalled stages hold valid and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            sq1 <= '0;
            g1  <= '0;
            g2  <= '0;
            om2 <= '0;
            d3  <= '0;
        end else begin
            if (ready1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    sq1 <= $unsigned(y_sq);
                    g1  <= bus.grad_data;
                end
            end
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    om2 <= om_nxt;
                    g2  <= g1;
                end
            end
            if (ready3) begin
                v3 <= v2;
                if (v2) begin
                    d3 <= out_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_tanh_backward_module.sv
// Scoreboard bench for tanh_backward_module: directed vectors,
// back-pressure, mid-stream reset.
module tb_tanh_backward_module;
    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

`ifdef TANH_BWD_ROUND_EN
    localparam logic [15:0] E_RP = 16'h0002;
    localparam logic [15:0] E_RN = 16'hFFFF;
`else
    localparam logic [15:0] E_RP = 16'h0001;
    localparam logic [15:0] E_RN = 16'hFFFE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   stall_seen = 1'b0;
    exp_t sb[$];

    logic [15:0] vy[9];
    logic [15:0] vg[9];
    logic [15:0] ve[9];

    tanh_backward_if #(.DATA_W(16)) bus();

    tanh_backward_module #(.DATA_W(16), .FRAC_W(12)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops and compares on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.in_valid && !bus.in_ready) stall_seen = 1'b1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {16'h0, bus.out_data}, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                chk("out_data", {16'h0, bus.out_data}, {16'h0, e.data});
                if (e.lat) chk("latency", cyc - e.cyc, 3);
            end
        end
    end

    task automatic send(input logic [15:0] y, input logic [15:0] g,
                        input logic [15:0] e, input bit lat);
        bit acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.y_data    = y;
        bus.grad_data = g;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{data: e, cyc: cyc, lat: lat});
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vy = '{16'h0000, 16'h0800, 16'h1000, 16'h1800, 16'hF800,
               16'h0B50, 16'h0B50, 16'h0000, 16'h8000};
        vg = '{16'h1000, 16'h2000, 16'h1234, 16'h7FFF, 16'hE000,
               16'h0003, 16'hFFFD, 16'h8000, 16'h1111};
        ve = '{16'h1000, 16'h1800, 16'h0000, 16'h0000, 16'hE800,
               E_RP,     E_RN,     16'h8000, 16'h0000};

        bus.in_valid  = 1'b0;
        bus.y_data    = '0;
        bus.grad_data = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("rst_out_data", {16'h0, bus.out_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'h0, bus.in_ready}, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) send(vy[i], vg[i], ve[i], 1'b1);
        drain();

        stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vy[i], vg[i], ve[i], 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(negedge clk);
                chk("ready_resume", {31'h0, bus.in_ready}, 1);
            end
        join
        drain();
        chk("stall_seen", {31'h0, stall_seen}, 1);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vy[i + 1], vg[i + 1], ve[i + 1], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", {31'h0, bus.in_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 0);
        chk("mid_rst_out_data", {16'h0, bus.out_data}, 0);
        chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 1);
        repeat (10) @(posedge clk);
        #1;
        send(vy[1], vg[1], ve[1], 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
